// File: rtl/sym_ser_pkg.sv
// rtl/sym_ser_pkg.sv - shared constants, defaults and state type for the symbol serializer
package sym_ser_pkg;

  localparam int SYM_W_DEF = 10;
  localparam int LANES_DEF = 1;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } ser_state_t;

endpackage

// File: rtl/sym_ser_if.sv
// rtl/sym_ser_if.sv - valid/ready symbol input bundle feeding the serializer
interface sym_ser_if
  import sym_ser_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF
);

  logic             s_valid;
  logic             s_ready;
  logic [SYM_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/sym_ser_fifo2.sv
// rtl/sym_ser_fifo2.sv - 2-entry symbol queue with registered ready and empty-queue bypass
module sym_ser_fifo2
  import sym_ser_pkg::*;
#(
  parameter int W = SYM_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push;
  logic         mem_push;
  logic         mem_pop;
  logic [1:0]   count_nxt;

  // A pop while empty consumes the symbol being pushed in the same cycle,
  // so that symbol never lands in storage.
  always_comb begin
    push      = push_valid && push_ready;
    mem_pop   = pop && (count != 2'd0);
    mem_push  = push && !(pop && (count == 2'd0));
    count_nxt = count + {1'b0, mem_push} - {1'b0, mem_pop};
    head_data = (count == 2'd0) ? push_data : mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      push_ready <= 1'b1;
    end else begin
      count      <= count_nxt;
      push_ready <= (count_nxt != 2'd2);
      if (mem_push) wr_ptr <= ~wr_ptr;
      if (mem_pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sym_serializer.sv
// rtl/sym_serializer.sv - parallel-to-serial symbol transmitter with idle insertion
// Optional error injection on queued symbols is enabled by SYM_SER_ERR_INJ_EN.
module sym_serializer
  import sym_ser_pkg::*;
#(
  parameter int               SYM_W     = SYM_W_DEF,
  parameter int               LANES     = LANES_DEF,
  parameter logic [SYM_W-1:0] IDLE_SYM  = SYM_W'(K28_5_RDN),
  parameter bit               MSB_FIRST = 1'b0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  sym_ser_if.slave         s_if,
`ifdef SYM_SER_ERR_INJ_EN
  input  logic             err_inj,
`endif
  output logic [LANES-1:0] sdata,
  output logic             sym_start,
  output logic             idle_out,
  output logic [CNT_W-1:0] idle_cnt
);

  localparam int                P         = SYM_W / LANES;
  localparam int                BEAT_W    = (P > 1) ? $clog2(P) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(P - 1);

  generate
    if (SYM_W % LANES != 0) begin : g_cfg_check
      $error("sym_serializer: SYM_W must be a multiple of LANES");
    end
  endgenerate

  logic [SYM_W-1:0]  sreg;
  logic [SYM_W-1:0]  head_data;
  logic [SYM_W-1:0]  load_sym;
  logic [BEAT_W-1:0] beat;
  logic [1:0]        q_count;
  logic              push;
  logic              head_avail;
  logic              boundary;
  logic              pop;
  ser_state_t        state;

  assign push       = s_if.s_valid && s_if.s_ready;
  assign head_avail = (q_count != 2'd0) || push;
  assign boundary   = (beat == LAST_BEAT);
  assign pop        = boundary && head_avail;

  sym_ser_fifo2 #(.W(SYM_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (s_if.s_valid),
    .push_ready (s_if.s_ready),
    .push_data  (s_if.s_data),
    .pop        (pop),
    .head_data  (head_data),
    .count      (q_count)
  );

`ifdef SYM_SER_ERR_INJ_EN
  assign load_sym = head_data ^ {{(SYM_W-1){1'b0}}, err_inj};
`else
  assign load_sym = head_data;
`endif

  // State only changes on the last beat, so a symbol always goes out whole.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg     <= IDLE_SYM;
      beat     <= '0;
      state    <= ST_IDLE;
      idle_cnt <= '0;
    end else if (boundary) begin
      beat <= '0;
      if (head_avail) begin
        sreg  <= load_sym;
        state <= ST_DATA;
      end else begin
        sreg  <= IDLE_SYM;
        state <= ST_IDLE;
        if (idle_cnt != {CNT_W{1'b1}}) idle_cnt <= idle_cnt + 1'b1;
      end
    end else begin
      beat <= beat + 1'b1;
      sreg <= MSB_FIRST ? (sreg << LANES) : (sreg >> LANES);
    end
  end

  generate
    if (MSB_FIRST) begin : g_msb
      assign sdata = sreg[SYM_W-1 -: LANES];
    end else begin : g_lsb
      assign sdata = sreg[LANES-1:0];
    end
  endgenerate

  assign sym_start = (beat == '0);
  assign idle_out  = (state == ST_IDLE);

endmodule

// File: tb/tb_sym_serializer.sv
// tb/tb_sym_serializer.sv - self-checking bench for sym_serializer against a queue-based model
module tb_sym_serializer;

  localparam logic [9:0] IDLE = 10'b0011111010;
  localparam int P_A = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
`ifdef SYM_SER_ERR_INJ_EN
  logic err_inj = 1'b0;
`endif

  sym_ser_if #(.SYM_W(10)) if_a ();
  sym_ser_if #(.SYM_W(10)) if_b ();

  logic        sdata_a;
  logic        sym_start_a, idle_out_a;
  logic [15:0] idle_cnt_a;
  logic [1:0]  sdata_b;
  logic        sym_start_b, idle_out_b;
  logic [1:0]  idle_cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sym_serializer #(.SYM_W(10), .LANES(1), .MSB_FIRST(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .s_if(if_a),
`ifdef SYM_SER_ERR_INJ_EN
    .err_inj(err_inj),
`endif
    .sdata(sdata_a), .sym_start(sym_start_a), .idle_out(idle_out_a), .idle_cnt(idle_cnt_a)
  );

  sym_serializer #(.SYM_W(10), .LANES(2), .MSB_FIRST(1'b1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .s_if(if_b),
`ifdef SYM_SER_ERR_INJ_EN
    .err_inj(1'b0),
`endif
    .sdata(sdata_b), .sym_start(sym_start_b), .idle_out(idle_out_b), .idle_cnt(idle_cnt_b)
  );

  // Reference model for dut_a: symbol schedule on fixed P-cycle slots plus a 2-deep queue.
  logic [9:0] m_cur;
  int         m_beat;
  bit         m_idle;
  int         m_cnt;
  bit         m_ready;
  logic [9:0] m_q[$];

  task automatic model_reset();
    m_cur = IDLE; m_beat = 0; m_idle = 1'b1; m_cnt = 0; m_ready = 1'b1;
    m_q.delete();
  endtask

  task automatic model_edge(input bit v, input logic [9:0] d, input bit inj);
    if (v && m_ready) m_q.push_back(d);
    if (m_beat == P_A - 1) begin
      m_beat = 0;
      if (m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        if (inj) m_cur[0] = ~m_cur[0];
        m_idle = 1'b0;
      end else begin
        m_cur = IDLE;
        m_idle = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end
    end else begin
      m_beat++;
    end
    m_ready = (m_q.size() < 2);
  endtask

  function automatic logic [19:0] exp_a();
    return {m_cur[m_beat], (m_beat == 0), m_idle, m_ready, 16'(m_cnt)};
  endfunction

  function automatic logic [19:0] got_a();
    return {sdata_a, sym_start_a, idle_out_a, if_a.s_ready, idle_cnt_a};
  endfunction

  task automatic tick_a(input bit v, input logic [9:0] d, input bit inj);
    if_a.s_valid = v;
    if_a.s_data  = d;
`ifdef SYM_SER_ERR_INJ_EN
    err_inj = inj;
`endif
    @(posedge clk); #1;
    model_edge(v, d, inj);
  endtask

  task automatic apply_reset();
    if_a.s_valid = 1'b0; if_b.s_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [19:0] ga;
    logic [6:0]  gb;
    if_a.s_valid = 1'b0; if_b.s_valid = 1'b0;
    if_a.s_data = '0; if_b.s_data = '0;
    rst = 1'b1;
    #3;
    for (int i = 0; i < 2; i++) begin
      ga = got_a();
      gb = {sdata_b, sym_start_b, idle_out_b, if_b.s_ready, idle_cnt_b};
      n_tests++;
      if (ga !== {1'b0, 1'b1, 1'b1, 1'b1, 16'h0}) begin
        n_fail++; $display("FAIL reset_a i=%0d got %h exp %h", i, ga, {1'b0, 1'b1, 1'b1, 1'b1, 16'h0});
      end
      n_tests++;
      if (gb !== {2'b00, 1'b1, 1'b1, 1'b1, 2'b00}) begin
        n_fail++; $display("FAIL reset_b i=%0d got %h exp %h", i, gb, {2'b00, 1'b1, 1'b1, 1'b1, 2'b00});
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_idle_stream();
    logic [9:0] pat = IDLE;
    apply_reset();
    for (int c = 0; c < 25; c++) begin
      n_tests++;
      if (got_a() !== exp_a()) begin
        n_fail++; $display("FAIL idle_stream c=%0d got %h exp %h", c, got_a(), exp_a());
      end
      n_tests++;
      if (sdata_a !== pat[c % 10]) begin
        n_fail++; $display("FAIL idle_bit c=%0d got %b exp %b", c, sdata_a, pat[c % 10]);
      end
      if (c == 10 || c == 20) begin
        n_tests++;
        if (idle_cnt_a !== 16'(c / 10)) begin
          n_fail++; $display("FAIL idle_cnt c=%0d got %0d exp %0d", c, idle_cnt_a, c / 10);
        end
      end
      tick_a(1'b0, 10'h0, 1'b0);
    end
  endtask

  task automatic test_single_push();
    apply_reset();
    for (int c = 0; c < 25; c++) begin
      n_tests++;
      if (got_a() !== exp_a()) begin
        n_fail++; $display("FAIL single_push c=%0d got %h exp %h", c, got_a(), exp_a());
      end
      if (c >= 10 && c < 20) begin
        n_tests++;
        if ({sdata_a, idle_out_a} !== {1'(((c - 10) % 2) == 0), 1'b0}) begin
          n_fail++; $display("FAIL data_155 c=%0d got %b%b exp %b0", c, sdata_a, idle_out_a, ((c - 10) % 2) == 0);
        end
      end
      if (c == 10 || c == 20) begin
        n_tests++;
        if (sym_start_a !== 1'b1) begin
          n_fail++; $display("FAIL sym_start c=%0d got %b exp 1", c, sym_start_a);
        end
      end
      tick_a(c == 2, 10'h155, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] syms[3];
    int idx = 0;
    bit v;
    for (int i = 0; i < 3; i++) syms[i] = 10'($urandom);
    apply_reset();
    for (int c = 0; c < 45; c++) begin
      n_tests++;
      if (got_a() !== exp_a()) begin
        n_fail++; $display("FAIL back_to_back c=%0d got %h exp %h", c, got_a(), exp_a());
      end
      if (c <= 10) begin
        n_tests++;
        if (if_a.s_ready !== 1'(c < 2 || c == 10)) begin
          n_fail++; $display("FAIL b2b_ready c=%0d got %b exp %b", c, if_a.s_ready, (c < 2 || c == 10));
        end
      end
      if (c >= 10 && c < 40) begin
        n_tests++;
        if (idle_out_a !== 1'b0) begin
          n_fail++; $display("FAIL b2b_bubble c=%0d idle_out got %b exp 0", c, idle_out_a);
        end
      end
      v = (idx < 3);
      if (v && m_ready) begin
        tick_a(1'b1, syms[idx], 1'b0);
        idx++;
      end else begin
        tick_a(v, v ? syms[idx] : 10'h0, 1'b0);
      end
    end
  endtask

  task automatic test_random();
    int dens[4] = '{20, 50, 90, 100};
    apply_reset();
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 100; c++) begin
        n_tests++;
        if (got_a() !== exp_a()) begin
          n_fail++; $display("FAIL random s=%0d c=%0d got %h exp %h", s, c, got_a(), exp_a());
        end
        tick_a($urandom_range(0, 99) < dens[s], 10'($urandom), 1'b0);
      end
    end
  endtask

  task automatic test_reset_mid_symbol();
    apply_reset();
    for (int c = 0; c < 24; c++) begin
      n_tests++;
      if (got_a() !== exp_a()) begin
        n_fail++; $display("FAIL pre_rst c=%0d got %h exp %h", c, got_a(), exp_a());
      end
      tick_a(c == 12 || c == 21, (c == 12) ? 10'h2A7 : 10'h0F3, 1'b0);
    end
    if_a.s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (got_a() !== {1'b0, 1'b1, 1'b1, 1'b1, 16'h0}) begin
      n_fail++; $display("FAIL mid_rst got %h exp %h", got_a(), {1'b0, 1'b1, 1'b1, 1'b1, 16'h0});
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    for (int c = 0; c < 30; c++) begin
      n_tests++;
      if (got_a() !== exp_a()) begin
        n_fail++; $display("FAIL post_rst c=%0d got %h exp %h", c, got_a(), exp_a());
      end
      tick_a(1'b0, 10'h0, 1'b0);
    end
  endtask

  task automatic test_msb_lanes2();
    logic [1:0] idle_beats[5] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b10};
    logic [1:0] data_beats[5] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b01};
    logic [6:0] gb, eb;
    bit         in_data;
    int         cnt;
    apply_reset();
    for (int c = 0; c < 36; c++) begin
      in_data = (c >= 5 && c < 10);
      cnt = (c < 10) ? 0 : (((c - 5) / 5) > 3 ? 3 : (c - 5) / 5);
      eb = {in_data ? data_beats[c % 5] : idle_beats[c % 5], 1'((c % 5) == 0), !in_data, 1'b1, 2'(cnt)};
      gb = {sdata_b, sym_start_b, idle_out_b, if_b.s_ready, idle_cnt_b};
      n_tests++;
      if (gb !== eb) begin
        n_fail++; $display("FAIL msb_lanes2 c=%0d got %h exp %h", c, gb, eb);
      end
      if_b.s_valid = (c == 0);
      if_b.s_data  = 10'b11_0110_0001;
      @(posedge clk); #1;
    end
    if_b.s_valid = 1'b0;
  endtask

`ifdef SYM_SER_ERR_INJ_EN
  task automatic test_err_inj();
    apply_reset();
    for (int c = 0; c < 30; c++) begin
      n_tests++;
      if (got_a() !== exp_a()) begin
        n_fail++; $display("FAIL err_inj c=%0d got %h exp %h", c, got_a(), exp_a());
      end
      if (c == 10 || c == 12) begin
        n_tests++;
        if (sdata_a !== 1'(c == 12)) begin
          n_fail++; $display("FAIL err_inj_bit c=%0d got %b exp %b", c, sdata_a, c == 12);
        end
      end
      tick_a(c == 2, 10'h155, c == 9);
    end
  endtask
`endif

  initial begin
    if_a.s_valid = 1'b0; if_a.s_data = '0;
    if_b.s_valid = 1'b0; if_b.s_data = '0;
    #2;
    test_reset();
    test_idle_stream();
    test_single_push();
    test_back_to_back();
    test_random();
    test_reset_mid_symbol();
    test_msb_lanes2();
`ifdef SYM_SER_ERR_INJ_EN
    test_err_inj();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sym_serializer.md
# sym_serializer

Parametrised parallel-to-serial symbol transmitter for the link interface. It accepts encoded line symbols (8b10b output by default) through a valid/ready handshake and buffers them in a 2-entry queue. It shifts each symbol out LANES bits per clock, and inserts a configurable idle/comma symbol whenever no data is queued. It replaces the fixed one-bit, two-clock serializer with a single-clock design that is generic in symbol width, lane count and bit order.

## Interface
Parameters:
- SYM_W, 10, symbol width in bits; must be a multiple of LANES (elaboration-time assertion).
- LANES, 1, bits emitted per clock.
- IDLE_SYM, 10'b0011111010 (K28.5, RD-), symbol inserted when the queue is empty; width SYM_W.
- MSB_FIRST, 0, 0 = symbol bit 0 leaves first; 1 = bit SYM_W-1 leaves first.
- CNT_W, 16, width of the idle counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  input symbol valid.
- s_ready  out  1  queue can accept a symbol.
- s_data  in  SYM_W  input symbol.
- sdata  out  LANES  serial output beat.
- sym_start  out  1  high on beat 0 of every symbol.
- idle_out  out  1  high for all beats of an inserted idle symbol.
- idle_cnt  out  CNT_W  saturating count of idle symbols inserted after reset.
- err_inj  in  1  error-injection request; present only with SYM_SER_ERR_INJ_EN.

## Operation
- Symbol period P = SYM_W/LANES cycles.
- Beat counter runs 0..P-1 and wraps.
- Shift register holds the current symbol.
  - MSB_FIRST=0: beat k drives sdata = sym[k*LANES +: LANES].
  - MSB_FIRST=1: beat k drives sdata = sym[SYM_W-1-k*LANES -: LANES], with lane LANES-1 carrying the higher bit.
- Load at boundary: on the clock edge ending beat P-1, the shift register loads one of the following.
  - Queue not empty: the queue head, which is popped; idle_out goes low.
  - Queue empty: IDLE_SYM; idle_out goes high and idle_cnt increments, saturating at 2^CNT_W-1.
- The FSM has two states, reflected in idle_out.
  - IDLE: sending IDLE_SYM.
  - DATA: sending a queued symbol.
  - Transitions happen only at symbol boundaries; a symbol is never truncated.
- Queue: 2 entries.
  - A push occurs when s_valid && s_ready.
  - s_ready is registered and equals count<2 for the next cycle; there is no combinational path from s_valid to s_ready.
- Simultaneous events:
  - Push and pop in the same cycle: count is unchanged; data order is preserved.
  - Push with count==2 is impossible because s_ready is low.
  - A pop on the boundary cycle raises s_ready on the next cycle.
- Reset (asynchronous, any time, including mid-symbol):
  - Shift register = IDLE_SYM, beat = 0, queue empty, idle_cnt = 0.
  - Outputs: sdata = beat 0 of IDLE_SYM, sym_start = 1, idle_out = 1, s_ready = 1.
  - Any partially sent symbol and all queued symbols are discarded.
  - The reset-loaded idle symbol is not counted.

## Timing
- Cycle numbering: cycle 0 is the first rising edge after rst falls.
- Beat k of the reset idle symbol is presented during cycle k.
- Boundary loads occur at cycles P-1, 2P-1, ...
- Latency: a symbol pushed into an empty queue at cycle t, with t ≤ the current boundary cycle, is emitted starting at the next boundary + 1.
  - Minimum latency is 1 cycle, when pushed on the boundary cycle itself.
  - Maximum latency is P cycles.
- Output timing:
  - sdata, idle_out and sym_start are registered or decoded from registers only.
  - idle_cnt updates one cycle after the boundary that loads an idle symbol.
- Throughput: one symbol per P cycles with continuous valid; no bubbles.

## Configuration
- Macro SYM_SER_ERR_INJ_EN.
- Defined:
  - The err_inj port exists.
  - If err_inj is high on a boundary cycle that loads a queued (non-idle) symbol, bit 0 of that symbol is inverted before transmission.
  - Idle symbols are never corrupted.
- Undefined: no err_inj port and no inversion logic; symbols are transmitted unmodified.

## Structure
- Package sym_ser_pkg holds:
  - K28_5_RDN / K28_5_RDP constants.
  - Default SYM_W and LANES localparams.
  - The state enum (ST_IDLE, ST_DATA).
- Sub-module sym_ser_fifo2 is the 2-entry queue: valid/ready on the push side, pop strobe, head data, count.
- Top level contains the beat counter, shift register, FSM and idle counter.

## Test plan
- Reset then no input, SYM_W=10, LANES=1 → sdata repeats 0,1,0,1,1,1,1,1,0,0 every 10 cycles; idle_out=1; idle_cnt=1 at cycle 10, 2 at cycle 20.
- Push 10'h155 at cycle 2 → sdata = 1,0,1,0,1,0,1,0,1,0 in cycles 10..19; idle_out=0 in cycles 10..19; sym_start=1 at cycles 10 and 20.
- Hold s_valid with 3 symbols from cycle 0 → accepts at cycles 0 and 1; s_ready=0 in cycles 2..9, 1 at cycle 10; third symbol accepted at cycle 10; all three emitted back-to-back from cycle 10 with no idle in between.
- LANES=2, MSB_FIRST=1, push 10'b11_0110_0001 → period 5 cycles; sdata = 2'b11, 2'b01, 2'b10, 2'b00, 2'b01.
- Assert rst at beat 4 of a data symbol with one symbol queued → outputs take reset values immediately; after release, the idle stream restarts at beat 0 and the queued symbol is never emitted.
- With SYM_SER_ERR_INJ_EN, err_inj=1 on boundary cycle 9 with 10'h155 queued → transmitted bits are 0,0,1,0,1,0,1,0,1,0; the following idle symbol is unchanged.
